// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encoding and baud divider helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - word handshake and serial line bundle for uart_tx_cfg
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] data;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (output start, output data, input tx, input busy, input done);
    modport slave  (input start, input data, output tx, output busy, output done);
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - loadable bit-period down-counter, tick on terminal count
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tick_o
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // Holds at zero between loads so the period only starts on a bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(CLKS_PER_BIT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter; UART_TX_BREAK_EN adds brk line-break input
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          reset_n,
`ifdef UART_TX_BREAK_EN
    input  logic          brk,
`endif
    uart_tx_cfg_if.slave  bus
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || CPB < 2) begin : g_bad_params
        $error("uart_tx_cfg: illegal parameter set");
    end

    logic brk_on;
`ifdef UART_TX_BREAK_EN
    assign brk_on = brk;
`else
    assign brk_on = 1'b0;
`endif

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_bit, tick_bit;

    uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_baud (
        .clk    (clk),
        .rst_n  (reset_n),
        .load_i (load_bit),
        .tick_o (tick_bit)
    );

    // tx is registered and set up one edge ahead, so each bit's level lands on its boundary.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_bit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = !brk_on;
                if (bus.start && !brk_on) begin
                    shreg_d  = bus.data;
                    par_d    = ^bus.data;
                    state_d  = ST_START;
                    busy_d   = 1'b1;
                    tx_d     = 1'b0;
                    load_bit = 1'b1;
                end
            end
            ST_START: begin
                if (tick_bit) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    load_bit  = 1'b1;
                end
            end
            ST_DATA: begin
                if (tick_bit) begin
                    load_bit = 1'b1;
                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                        if (PARITY == PAR_NONE) begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end else begin
                            state_d = ST_PARITY;
                            tx_d    = (PARITY == PAR_EVEN) ? par_q : ~par_q;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick_bit) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                    load_bit   = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick_bit) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                        load_bit   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. Serialises a DATA_BITS-wide word as follows: start bit, data LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing comes from an internal divider derived from CLK_FREQ/BAUD. Sits between the system-side byte producer (CPU or FIFO logic) and the board TX pin on the Tang Primer 25K.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD, truncated, must be >= 2.
DATA_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request to send; sampled only when busy=0.
data  in  DATA_BITS  word to transmit; captured on the accepting edge.
tx  out  1  serial line, idle high.
busy  out  1  high from the cycle after acceptance until the frame completes.
done  out  1  one-cycle pulse when the last stop bit finishes.

Behaviour:
- Reset (reset_n=0, asynchronous): tx=1, busy=0, done=0, state IDLE, counters cleared. Reset asserted mid-frame aborts the frame immediately and forces tx high, with no glitch low.
- Acceptance: a rising edge with start=1 and busy=0 latches data into the shift register. On that same edge: state moves to START, busy goes to 1, tx goes to 0, and the bit counter loads CLKS_PER_BIT-1.
- start is ignored while busy=1. data changes during a frame have no effect.
- FSM states: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (skipped when PARITY=0) -> STOP (STOP_BITS bits) -> IDLE.
- Bit period: every bit holds tx for exactly CLKS_PER_BIT cycles. The baud counter reloads at each bit boundary; it does not free-run.
- Data order: LSB first. The shift register shifts right at each data-bit boundary.
- Parity: computed as XOR of the latched word. Even mode sends the XOR result; odd mode sends its inverse.
- Completion: on the last cycle of the final stop bit, the FSM returns to IDLE. busy becomes 0 and done becomes 1 for one cycle, both visible after that edge.
- Frame length: (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) x CLKS_PER_BIT cycles, measured from acceptance to busy falling.
- Back-to-back: start=1 held continuously starts the next frame on the edge where busy is 0, i.e. the cycle done=1. The idle gap is exactly 1 clock.
- Elaboration: illegal parameter values (DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1/2, CLKS_PER_BIT<2) trigger an elaboration-time error.

Optional Feature:
UART_TX_BREAK_EN:
- When defined, adds input port brk (1 bit). While brk=1 and busy=0, tx is held at 0 (line break) and start is ignored. Releasing brk returns tx to 1 on the next edge. brk asserted while busy=1 is deferred until the frame ends.
- When undefined, the brk port does not exist and behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - a constant function clks_per_bit(clk_freq, baud).
- One natural sub-module, uart_baud_tick: a loadable down-counter of width clog2(CLKS_PER_BIT). It takes a load input and produces a tick on the terminal count. The same block is reusable by a later uart_rx_cfg.

Test Plan:
- Defaults (8N1, CLKS_PER_BIT=434): 1-cycle start pulse with data=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 434 cycles. busy high for 4340 cycles, then one done pulse.
- PARITY=2, then PARITY=1, data=0xA5 (four ones) -> parity bit 0 for even and 1 for odd. Frame is 11 bits = 4774 cycles.
- DATA_BITS=7, STOP_BITS=2, data=7'h41 -> tx sequence 0,1,0,0,0,0,0,1,1,1. Frame is 10 bits; the stop level lasts 868 cycles.
- start held high with 0x55 then 0x0F -> exactly 1 idle cycle (tx=1, busy=0, done=1) between frames. A second start pulse mid-frame is ignored, with no frame corruption.
- reset_n pulled low during data bit 3 -> tx=1 and busy=0 asynchronously, before the next clock edge. After release, a new start sends a clean full frame.
- UART_TX_BREAK_EN: brk=1 while idle -> tx=0 and start ignored. brk=1 mid-frame -> frame completes unchanged, then tx drops to 0 after done.
